// File: rtl/harness_acc_pkg.sv
// Shared types and defaults for the product accumulator harness.
// Optional build macro: HARNESS_ACC_SAT_EN (saturating accumulate).
package harness_acc_pkg;

    localparam int PROD_W_DEF  = 13;
    localparam int ACC_W_DEF   = 20;
    localparam int MAX_LEN_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    // Sign-extend the low pw bits of p to 64 bits; callers narrow to ACC_W.
    function automatic logic signed [63:0] sext_prod(input logic [63:0] p, input int pw);
        logic signed [63:0] t;
        t = p << (64 - pw);
        return t >>> (64 - pw);
    endfunction

endpackage

// File: rtl/harness_acc_sat_add.sv
// Sign-extend a product, add it to the accumulator, flag signed overflow.
// HARNESS_ACC_SAT_EN selects clamping on overflow instead of wrapping.
module harness_acc_sat_add
    import harness_acc_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [PROD_W-1:0] prod,
    output logic signed [ACC_W-1:0]  sum,
    output logic                     ovf
);

    logic signed [ACC_W-1:0] b;
    logic signed [ACC_W-1:0] raw;

    always_comb begin
        b   = ACC_W'(sext_prod(64'(prod), PROD_W));
        raw = acc + b;
        ovf = (acc[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);
`ifdef HARNESS_ACC_SAT_EN
        // Both operands share a sign on overflow, so acc's sign picks the rail.
        if (ovf)
            sum = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            sum = raw;
`else
        sum = raw;
`endif
    end

endmodule

// File: rtl/harness_prod_acc_13s.sv
// Framed accumulator for signed products with handshaked sum output.
// Build macro HARNESS_ACC_SAT_EN enables saturating accumulation.
module harness_prod_acc_13s
    import harness_acc_pkg::*;
#(
    parameter  int PROD_W  = PROD_W_DEF,
    parameter  int ACC_W   = ACC_W_DEF,
    parameter  int MAX_LEN = MAX_LEN_DEF,
    localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic signed [PROD_W-1:0] prod_tdata,
    input  logic                     prod_tvalid,
    output logic                     prod_tready,
    input  logic                     prod_tlast,
    output logic signed [ACC_W-1:0]  sum_tdata,
    output logic                     sum_tvalid,
    input  logic                     sum_tready,
    output logic [CNT_W-1:0]         sum_count,
    output logic                     sum_ovf
);

    state_t                  state, state_nxt;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic                    ovf_r;
    logic signed [ACC_W-1:0] add_sum;
    logic                    add_ovf;
    logic                    accept;
    logic                    at_limit;

    harness_acc_sat_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc  (acc),
        .prod (prod_tdata),
        .sum  (add_sum),
        .ovf  (add_ovf)
    );

    assign accept   = prod_tvalid && prod_tready;
    assign at_limit = (cnt == CNT_W'(MAX_LEN - 1));

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (prod_tlast || MAX_LEN == 1) ? OUT : ACCUM;
            ACCUM:   if (accept && (prod_tlast || at_limit)) state_nxt = OUT;
            OUT:     if (sum_tready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        prod_tready = (state != OUT) && !ap_rst;
        sum_tvalid  = (state == OUT);
    end

    // First beat of a frame loads the accumulator; later beats go through the adder.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            acc   <= '0;
            cnt   <= '0;
            ovf_r <= 1'b0;
        end else if (accept) begin
            if (state == IDLE) begin
                acc   <= ACC_W'(sext_prod(64'(prod_tdata), PROD_W));
                cnt   <= CNT_W'(1);
                ovf_r <= 1'b0;
            end else begin
                acc   <= add_sum;
                cnt   <= cnt + CNT_W'(1);
                ovf_r <= ovf_r | add_ovf;
            end
        end
    end

    assign sum_tdata = acc;
    assign sum_count = cnt;
    assign sum_ovf   = ovf_r;

endmodule

// File: tb/tb_harness_prod_acc_13s.sv
// Directed and model-checked bench for harness_prod_acc_13s (main and 14-bit accumulator instances).
module tb_harness_prod_acc_13s;

    localparam int PW  = 13;
    localparam int AW  = 20;
    localparam int ML  = 16;
    localparam int CW  = 5;
    localparam int SAW = 14;

    logic ap_clk = 1'b0;
    logic ap_rst;
    always #5 ap_clk = ~ap_clk;

    logic signed [PW-1:0] prod_tdata;
    logic                 prod_tvalid, prod_tready, prod_tlast;
    logic signed [AW-1:0] sum_tdata;
    logic                 sum_tvalid, sum_tready;
    logic [CW-1:0]        sum_count;
    logic                 sum_ovf;

    logic signed [PW-1:0]  s_prod_tdata;
    logic                  s_prod_tvalid, s_prod_tready, s_prod_tlast;
    logic signed [SAW-1:0] s_sum_tdata;
    logic                  s_sum_tvalid, s_sum_tready;
    logic [CW-1:0]         s_sum_count;
    logic                  s_sum_ovf;

    int tests = 0;
    int fails = 0;

    harness_prod_acc_13s #(.PROD_W(PW), .ACC_W(AW), .MAX_LEN(ML)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .prod_tdata(prod_tdata), .prod_tvalid(prod_tvalid), .prod_tready(prod_tready),
        .prod_tlast(prod_tlast),
        .sum_tdata(sum_tdata), .sum_tvalid(sum_tvalid), .sum_tready(sum_tready),
        .sum_count(sum_count), .sum_ovf(sum_ovf)
    );

    harness_prod_acc_13s #(.PROD_W(PW), .ACC_W(SAW), .MAX_LEN(ML)) dut_s (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .prod_tdata(s_prod_tdata), .prod_tvalid(s_prod_tvalid), .prod_tready(s_prod_tready),
        .prod_tlast(s_prod_tlast),
        .sum_tdata(s_sum_tdata), .sum_tvalid(s_sum_tvalid), .sum_tready(s_sum_tready),
        .sum_count(s_sum_count), .sum_ovf(s_sum_ovf)
    );

    // Present one beat on the main DUT; returns #1 after the accepting edge.
    task automatic send(input int d, input logic l);
        int n = 0;
        prod_tdata  = PW'(d);
        prod_tlast  = l;
        prod_tvalid = 1'b1;
        @(negedge ap_clk);
        while (prod_tready !== 1'b1 && n < 200) begin
            @(negedge ap_clk);
            n++;
        end
        if (n >= 200) begin
            tests++; fails++;
            $display("FAIL send_timeout: prod_tready stuck at %b, required 1", prod_tready);
        end
        @(posedge ap_clk); #1;
        prod_tvalid = 1'b0;
        prod_tlast  = 1'b0;
    endtask

    task automatic s_send(input int d, input logic l);
        int n = 0;
        s_prod_tdata  = PW'(d);
        s_prod_tlast  = l;
        s_prod_tvalid = 1'b1;
        @(negedge ap_clk);
        while (s_prod_tready !== 1'b1 && n < 200) begin
            @(negedge ap_clk);
            n++;
        end
        if (n >= 200) begin
            tests++; fails++;
            $display("FAIL s_send_timeout: prod_tready stuck at %b, required 1", s_prod_tready);
        end
        @(posedge ap_clk); #1;
        s_prod_tvalid = 1'b0;
        s_prod_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst = 1'b1;
        repeat (2) @(posedge ap_clk);
        #1;
        tests++; if (prod_tready !== 1'b0) begin fails++; $display("FAIL rst_tready: got %b required 0", prod_tready); end
        tests++; if (sum_tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid: got %b required 0", sum_tvalid); end
        tests++; if (sum_tdata !== '0) begin fails++; $display("FAIL rst_sum: got %0d required 0", sum_tdata); end
        tests++; if (sum_count !== '0) begin fails++; $display("FAIL rst_count: got %0d required 0", sum_count); end
        tests++; if (sum_ovf !== 1'b0) begin fails++; $display("FAIL rst_ovf: got %b required 0", sum_ovf); end
        ap_rst = 1'b0;
        #1;
        tests++; if (prod_tready !== 1'b1) begin fails++; $display("FAIL rst_release_tready: got %b required 1", prod_tready); end
    endtask

    task automatic test_frame();
        sum_tready = 1'b1;
        send(100, 1'b0);
        tests++; if (sum_tvalid !== 1'b0) begin fails++; $display("FAIL t1_early_valid: got %b required 0", sum_tvalid); end
        send(-50, 1'b0);
        send(7, 1'b1);
        tests++; if (sum_tvalid !== 1'b1) begin fails++; $display("FAIL t1_valid: got %b required 1", sum_tvalid); end
        tests++; if (sum_tdata !== 20'sd57) begin fails++; $display("FAIL t1_sum: got %0d required 57", sum_tdata); end
        tests++; if (sum_count !== 5'd3) begin fails++; $display("FAIL t1_count: got %0d required 3", sum_count); end
        tests++; if (sum_ovf !== 1'b0) begin fails++; $display("FAIL t1_ovf: got %b required 0", sum_ovf); end
        @(posedge ap_clk); #1;
        tests++; if (sum_tvalid !== 1'b0) begin fails++; $display("FAIL t1_drop: got %b required 0", sum_tvalid); end
    endtask

    task automatic test_max_len();
        sum_tready = 1'b1;
        for (int i = 0; i < 16; i++) send(4095, 1'b0);
        tests++; if (sum_tvalid !== 1'b1) begin fails++; $display("FAIL t2_valid: got %b required 1", sum_tvalid); end
        tests++; if (sum_tdata !== 20'sd65520) begin fails++; $display("FAIL t2_sum: got %0d required 65520", sum_tdata); end
        tests++; if (sum_count !== 5'd16) begin fails++; $display("FAIL t2_count: got %0d required 16", sum_count); end
        @(posedge ap_clk); #1;
        send(5, 1'b1);
        tests++; if (sum_tdata !== 20'sd5 || sum_count !== 5'd1 || sum_tvalid !== 1'b1)
            begin fails++; $display("FAIL t2_next: got sum %0d count %0d valid %b required 5 1 1", sum_tdata, sum_count, sum_tvalid); end
        @(posedge ap_clk); #1;
    endtask

    task automatic test_overflow();
        int xa, xb, xd;
`ifdef HARNESS_ACC_SAT_EN
        xa = 8191; xb = -8192; xd = 4095;
`else
        xa = -4099; xb = 4096; xd = 8189;
`endif
        s_sum_tready = 1'b1;
        s_send(4095, 1'b0); s_send(4095, 1'b0); s_send(4095, 1'b1);
        tests++; if (s_sum_tdata !== SAW'(xa) || s_sum_ovf !== 1'b1 || s_sum_count !== 5'd3)
            begin fails++; $display("FAIL t3_pos: got sum %0d ovf %b count %0d required %0d 1 3", s_sum_tdata, s_sum_ovf, s_sum_count, xa); end
        @(posedge ap_clk); #1;
        s_send(-4096, 1'b0); s_send(-4096, 1'b0); s_send(-4096, 1'b1);
        tests++; if (s_sum_tdata !== SAW'(xb) || s_sum_ovf !== 1'b1)
            begin fails++; $display("FAIL t3_neg: got sum %0d ovf %b required %0d 1", s_sum_tdata, s_sum_ovf, xb); end
        @(posedge ap_clk); #1;
        s_send(1, 1'b1);
        tests++; if (s_sum_tdata !== 14'sd1 || s_sum_ovf !== 1'b0)
            begin fails++; $display("FAIL t3_clear: got sum %0d ovf %b required 1 0", s_sum_tdata, s_sum_ovf); end
        @(posedge ap_clk); #1;
        s_send(4095, 1'b0); s_send(4095, 1'b0); s_send(4095, 1'b0); s_send(-4096, 1'b1);
        tests++; if (s_sum_tdata !== SAW'(xd) || s_sum_ovf !== 1'b1 || s_sum_count !== 5'd4)
            begin fails++; $display("FAIL t3_sticky: got sum %0d ovf %b count %0d required %0d 1 4", s_sum_tdata, s_sum_ovf, s_sum_count, xd); end
        @(posedge ap_clk); #1;
    endtask

    task automatic test_backpressure();
        sum_tready = 1'b0;
        send(10, 1'b0);
        send(20, 1'b1);
        prod_tdata = 13'sd33; prod_tlast = 1'b1; prod_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            tests++; if (prod_tready !== 1'b0 || sum_tvalid !== 1'b1 || sum_tdata !== 20'sd30 || sum_count !== 5'd2)
                begin fails++; $display("FAIL t4_hold%0d: got tready %b valid %b sum %0d count %0d required 0 1 30 2", i, prod_tready, sum_tvalid, sum_tdata, sum_count); end
        end
        sum_tready = 1'b1;
        @(posedge ap_clk); #1;
        tests++; if (sum_tvalid !== 1'b0 || prod_tready !== 1'b1)
            begin fails++; $display("FAIL t4_release: got valid %b tready %b required 0 1", sum_tvalid, prod_tready); end
        @(posedge ap_clk); #1;
        prod_tvalid = 1'b0; prod_tlast = 1'b0;
        tests++; if (sum_tvalid !== 1'b1 || sum_tdata !== 20'sd33 || sum_count !== 5'd1)
            begin fails++; $display("FAIL t4_next: got valid %b sum %0d count %0d required 1 33 1", sum_tvalid, sum_tdata, sum_count); end
        @(posedge ap_clk); #1;
    endtask

    task automatic test_reset_midframe();
        sum_tready = 1'b1;
        send(11, 1'b0);
        send(22, 1'b0);
        ap_rst = 1'b1;
        #1;
        tests++; if (prod_tready !== 1'b0 || sum_tvalid !== 1'b0 || sum_tdata !== '0 || sum_count !== '0 || sum_ovf !== 1'b0)
            begin fails++; $display("FAIL t5_rst: got tready %b valid %b sum %0d count %0d ovf %b required all 0", prod_tready, sum_tvalid, sum_tdata, sum_count, sum_ovf); end
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        tests++; if (sum_tvalid !== 1'b0) begin fails++; $display("FAIL t5_no_emit: got %b required 0", sum_tvalid); end
        @(posedge ap_clk); #1;
        send(-4096, 1'b1);
        tests++; if (sum_tvalid !== 1'b1 || sum_tdata !== -20'sd4096 || sum_count !== 5'd1 || sum_ovf !== 1'b0)
            begin fails++; $display("FAIL t5_post: got valid %b sum %0d count %0d ovf %b required 1 -4096 1 0", sum_tvalid, sum_tdata, sum_count, sum_ovf); end
        @(posedge ap_clk); #1;
    endtask

    task automatic test_random();
        int     bd[$];
        bit     bl[$];
        longint es[$];
        int     ec[$];
        bit     eo[$];
        longint acc, t, amax, amin;
        int     cnt, rcv, total;
        bit     ovf;
        amax = (longint'(1) <<< (AW - 1)) - 1;
        amin = -(longint'(1) <<< (AW - 1));
        for (int f = 0; f < 1000; f++) begin
            int len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) begin
                int v = $urandom_range(0, 8191);
                if (v >= 4096) v -= 8192;
                bd.push_back(v);
                bl.push_back(i == len - 1);
            end
        end
        cnt = 0; acc = 0; ovf = 0;
        foreach (bd[i]) begin
            if (cnt == 0) begin
                acc = bd[i]; ovf = 0;
            end else begin
                t = acc + bd[i];
                if (t > amax || t < amin) begin
                    ovf = 1;
`ifdef HARNESS_ACC_SAT_EN
                    t = (t > amax) ? amax : amin;
`else
                    t = t - ((t > amax) ? (amax - amin + 1) : -(amax - amin + 1));
`endif
                end
                acc = t;
            end
            cnt++;
            if (bl[i] || cnt == ML) begin
                es.push_back(acc); ec.push_back(cnt); eo.push_back(ovf);
                cnt = 0;
            end
        end
        total = es.size();
        rcv = 0;
        fork
            begin
                for (int k = 0; k < bd.size(); k++) begin
                    repeat ($urandom_range(0, 2)) @(posedge ap_clk);
                    #1;
                    send(bd[k], bl[k]);
                end
            end
            begin
                int cyc = 0;
                while (rcv < total && cyc < 80000) begin
                    @(posedge ap_clk); #1;
                    sum_tready = ($urandom_range(0, 3) != 0);
                    @(negedge ap_clk);
                    if (sum_tvalid && sum_tready) begin
                        logic signed [AW-1:0] xs;
                        logic [CW-1:0]        xc;
                        logic                 xo;
                        xs = AW'(es.pop_front()); xc = CW'(ec.pop_front()); xo = eo.pop_front();
                        tests++;
                        if (sum_tdata !== xs || sum_count !== xc || sum_ovf !== xo) begin
                            fails++;
                            $display("FAIL t6_frame%0d: got sum %0d count %0d ovf %b required %0d %0d %b", rcv, sum_tdata, sum_count, sum_ovf, xs, xc, xo);
                        end
                        rcv++;
                    end
                    cyc++;
                end
            end
        join
        @(posedge ap_clk); #1;
        sum_tready = 1'b1;
        tests++; if (rcv != total) begin fails++; $display("FAIL t6_count: got %0d frames required %0d", rcv, total); end
    endtask

    initial begin
        ap_rst = 1'b1;
        prod_tdata = '0; prod_tvalid = 1'b0; prod_tlast = 1'b0; sum_tready = 1'b0;
        s_prod_tdata = '0; s_prod_tvalid = 1'b0; s_prod_tlast = 1'b0; s_sum_tready = 1'b0;
        test_reset();
        test_frame();
        test_max_len();
        test_overflow();
        test_backpressure();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
